des_sbox_scheduler: RTL and testbench
=====================================

// Module: des_sbox_scheduler
// PURPOSE
//  Sequences the eight DES S-box lookup units for one Feistel round. Accepts the
//  48-bit E(R) xor K value, drives each S-box unit in turn with its 6-bit slice via
//  one-hot selects, captures each 4-bit result on that unit's finish flag, and
//  returns the packed 32-bit S-layer output (pre-P) over a valid/ready handshake.
// PARAMETERS
//  PIPELINED       1  1: issue one box per cycle back-to-back; 0: issue next box only after previous finish
//  TIMEOUT_CYCLES  4  cycles after an issue within which the finish flag must arrive (>=1)
// PORTS
//  clk          in   1   clock, all logic on posedge
//  rst          in   1   synchronous reset, active-high
//  in_valid     in   1   in_data valid
//  in_ready     out  1   block can accept in_data
//  in_data      in   48  [48:43] -> S1 ... [6:1] -> S8 (DES bit order, S1 at MSB)
//  out_valid    out  1   out_data valid, held until out_ready
//  out_ready    in   1   consumer accepts out_data
//  out_data     out  32  [32:29] = S1 result ... [4:1] = S8 result
//  sbox_sel     out  8   one-hot select, bit k drives S-box k Select (bit 1 = S1)
//  sbox_input   out  6   slice broadcast to all S-box inputs
//  sbox_result  in   32  concatenated S-box outputs, same packing as out_data
//  sbox_finish  in   8   finish flags, bit k from S-box k
//  err          out  1   sticky timeout error, cleared only by rst
// BEHAVIOUR
//  - Reset values: state IDLE, in_ready=1, out_valid=0, out_data=0, sbox_sel=0,
//    sbox_input=0, err=0, issue/capture counters=0. rst wins over every other input.
//  - S-box units register their result and finish one cycle after select (finish=1
//    while selected, 0 the cycle after deselect).
//  - States: IDLE -> RUN -> DONE -> IDLE; any timeout -> IDLE.
//  - IDLE: in_ready=1; in_valid&in_ready at edge T0 latches in_data, clears out_data,
//    goes RUN. in_ready=0 in every other state.
//  - RUN, PIPELINED=1: cycle after T0+k-1 drives sbox_sel[k]=1, sbox_input=slice k,
//    k=1..8; captures sbox_result slice k at the edge where sbox_finish[k]=1.
//    Last capture at T9; out_valid=1 from T9 -> 9-cycle accept-to-valid latency.
//  - RUN, PIPELINED=0: drive box k, hold sel until finish[k] seen, capture, deassert
//    for one cycle, then box k+1 -> 2 cycles per box, out_valid at T16.
//  - sbox_sel is 0 on any cycle with no issue; never more than one bit set.
//  - Finish on a non-pending box is ignored. Captures write only their own nibble.
//  - Timeout: pending box k without finish[k] for TIMEOUT_CYCLES cycles after its
//    issue -> err=1 (sticky), sel cleared, state IDLE, out_valid never asserted for
//    that transaction; further transactions still accepted.
//  - DONE: out_valid=1, out_data stable until out_valid&out_ready; then IDLE next
//    edge (in_ready=1 the cycle after handshake; no same-cycle out/in overlap).
//  - rst mid-RUN or mid-DONE: all state discarded at that edge, reset values apply.
// TESTING
//  1 rst 2 cycles -> in_ready=1, out_valid=0, sbox_sel=0, err=0, out_data=0.
//  2 PIPELINED=1, in_data=48'h6117BA866527 -> out_data=32'h5C82B597, out_valid 9
//    cycles after accept, sbox_sel walks 8'h01..8'h80 on consecutive cycles.
//  3 in_data=0, out_ready low 5 cycles -> out_data=32'hEFA72C4D held, in_ready=0,
//    in_valid pulses ignored; release out_ready -> in_ready=1 next cycle.
//  4 PIPELINED=0, in_data=48'h6117BA866527 -> 32'h5C82B597 at 16 cycles, gap cycle
//    with sbox_sel=0 between every issue.
//  5 sbox_finish[3] forced 0, TIMEOUT_CYCLES=4 -> err=1 4 cycles after S3 issue,
//    IDLE, no out_valid; next transaction (in_data=0) -> 32'hEFA72C4D, err stays 1.
//  6 rst pulsed in 4th RUN cycle -> reset values next edge; following 48'h0 ->
//    32'hEFA72C4D with normal latency.

Source files
------------

// File: rtl/des_sbox_scheduler.sv
// Sequences the eight DES S-box units for one Feistel round: issues each 6-bit slice
// with a one-hot select, gathers the 4-bit results and returns the packed S-layer word.
module des_sbox_scheduler #(
    parameter bit PIPELINED      = 1'b1,
    parameter int TIMEOUT_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [7:0]  sbox_sel,
    output logic [5:0]  sbox_input,
    input  logic [31:0] sbox_result,
    input  logic [7:0]  sbox_finish,
    output logic        err
);
    localparam int AW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [AW-1:0] AGE_MAX = AW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;

    logic [47:0]   data_q, issue_src, issue_shift;
    logic [7:0]    pending, cap_mask, to_mask;
    logic [AW-1:0] age [8];
    logic [3:0]    issue_cnt, cap_cnt, cap_num;
    logic [2:0]    issue_idx;
    logic          accept, issue_go, timeout, last_cap;

    always_comb begin
        accept   = (state == IDLE) && in_valid;
        cap_mask = '0;
        to_mask  = '0;
        cap_num  = '0;
        for (int k = 0; k < 8; k++) begin
            if (state == RUN && pending[k]) begin
                if (sbox_finish[k]) begin
                    cap_mask[k] = 1'b1;
                    cap_num     = cap_num + 4'd1;
                end else if (age[k] == AGE_MAX) begin
                    to_mask[k] = 1'b1;
                end
            end
        end
        timeout  = |to_mask;
        last_cap = (state == RUN) && !timeout &&
                   (({1'b0, cap_cnt} + {1'b0, cap_num}) == 5'd8);
        // Sequential mode waits until nothing is left outstanding after this edge's captures.
        issue_go = accept ||
                   ((state == RUN) && !timeout && (issue_cnt < 4'd8) &&
                    (PIPELINED || ((pending & ~cap_mask) == 8'd0)));
        issue_idx   = accept ? 3'd0 : issue_cnt[2:0];
        issue_src   = accept ? in_data : data_q;
        issue_shift = issue_src << (6 * issue_idx);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN: begin
                if (timeout)       state_nxt = IDLE;
                else if (last_cap) state_nxt = DONE;
            end
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q     <= '0;
            out_data   <= '0;
            sbox_sel   <= '0;
            sbox_input <= '0;
            err        <= 1'b0;
            pending    <= '0;
            issue_cnt  <= '0;
            cap_cnt    <= '0;
            for (int k = 0; k < 8; k++) age[k] <= '0;
        end else begin
            sbox_sel   <= '0;
            sbox_input <= '0;
            if (accept) begin
                data_q   <= in_data;
                out_data <= '0;
                cap_cnt  <= '0;
            end
            for (int k = 0; k < 8; k++) begin
                if (cap_mask[k]) begin
                    out_data[31-4*k -: 4] <= sbox_result[31-4*k -: 4];
                    pending[k]            <= 1'b0;
                end else if (pending[k]) begin
                    age[k] <= age[k] + 1'b1;
                end
            end
            if (state == RUN) cap_cnt <= cap_cnt + cap_num;
            if (issue_go) begin
                sbox_sel           <= 8'd1 << issue_idx;
                sbox_input         <= issue_shift[47:42];
                pending[issue_idx] <= 1'b1;
                age[issue_idx]     <= '0;
                issue_cnt          <= accept ? 4'd1 : issue_cnt + 4'd1;
            end
            // A stalled unit abandons the whole transaction; late finishes are then ignored.
            if (timeout) begin
                pending <= '0;
                err     <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_des_sbox_scheduler.sv
// Bench for des_sbox_scheduler: one pipelined and one sequential instance, each driving
// a behavioural S-box model built from the DES tables.
module tb_des_sbox_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid    [2];
    logic        in_ready    [2];
    logic [47:0] in_data     [2];
    logic        out_valid   [2];
    logic        out_ready   [2];
    logic [31:0] out_data    [2];
    logic [7:0]  sbox_sel    [2];
    logic [5:0]  sbox_input  [2];
    logic [31:0] sbox_result [2];
    logic [7:0]  sbox_finish [2];
    logic        err         [2];
    logic [7:0]  kill        [2];
    logic [7:0]  sel_log     [40];

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    des_sbox_scheduler #(.PIPELINED(1'b1), .TIMEOUT_CYCLES(4)) u_pipe (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(out_data[0]), .sbox_sel(sbox_sel[0]), .sbox_input(sbox_input[0]),
        .sbox_result(sbox_result[0]), .sbox_finish(sbox_finish[0]), .err(err[0])
    );

    des_sbox_scheduler #(.PIPELINED(1'b0), .TIMEOUT_CYCLES(4)) u_seq (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(out_data[1]), .sbox_sel(sbox_sel[1]), .sbox_input(sbox_input[1]),
        .sbox_result(sbox_result[1]), .sbox_finish(sbox_finish[1]), .err(err[1])
    );

    int SB [512] = '{
        14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,  0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
        4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,  15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
        15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,  3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
        0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,  13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
        10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,  13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
        13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,  1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
        7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,  13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
        10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,  3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
        2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,  14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
        4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,  11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
        12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,  10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
        9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,  4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
        4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,  13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
        1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,  6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
        13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,  1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
        7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,  2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11
    };

    // Outer bits pick the row, inner four the column.
    function automatic logic [3:0] sb(int n, logic [5:0] x);
        int row, col;
        row = {x[5], x[0]};
        col = x[4:1];
        return 4'(SB[n*64 + row*16 + col]);
    endfunction

    function automatic logic [31:0] ref_out(logic [47:0] v);
        logic [31:0] r;
        for (int k = 0; k < 8; k++) r[31-4*k -: 4] = sb(k, v[47-6*k -: 6]);
        return r;
    endfunction

    // S-box units: register result and finish one cycle after select.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 8; k++) begin
                if (rst) sbox_finish[d][k] <= 1'b0;
                else     sbox_finish[d][k] <= sbox_sel[d][k] & ~kill[d][k];
                if (sbox_sel[d][k]) sbox_result[d][31-4*k -: 4] <= sb(k, sbox_input[d]);
            end
        end
    end

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
            $error("check %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one word and wait (bounded) for out_valid; lat counts edges after the accept edge.
    task automatic txn(int d, logic [47:0] v, output logic [31:0] got, output int lat);
        in_data[d]  = v;
        in_valid[d] = 1'b1;
        tick();
        in_valid[d] = 1'b0;
        lat = 0;
        while (out_valid[d] !== 1'b1 && lat < 40) begin
            sel_log[lat] = sbox_sel[d];
            tick();
            lat++;
        end
        got = out_data[d];
    endtask

    task automatic check_reset(int d, string tag);
        check({tag, " in_ready"},  64'(in_ready[d]),  1);
        check({tag, " out_valid"}, 64'(out_valid[d]), 0);
        check({tag, " sbox_sel"},  64'(sbox_sel[d]),  0);
        check({tag, " err"},       64'(err[d]),       0);
        check({tag, " out_data"},  64'(out_data[d]),  0);
    endtask

    initial begin
        logic [31:0] got;
        logic [47:0] v;
        int lat, err_at, saw_ov, h, d;

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid[i] = 1'b0; in_data[i] = '0; out_ready[i] = 1'b1; kill[i] = '0;
        end
        tick();
        tick();
        check_reset(0, "rst pipe");
        check_reset(1, "rst seq");
        rst = 1'b0;

        // Pipelined reference vector
        txn(0, 48'h6117BA866527, got, lat);
        check("pipe data", 64'(got), 32'h5C82B597);
        check("pipe latency", 64'(lat), 9);
        for (int i = 0; i < 9; i++)
            check($sformatf("pipe sel walk %0d", i), 64'(sel_log[i]), (i < 8) ? (64'd1 << i) : 64'd0);
        tick();
        check("pipe in_ready after hs", 64'(in_ready[0]), 1);
        check("pipe out_valid after hs", 64'(out_valid[0]), 0);

        // Output back-pressure with ignored input pulses
        out_ready[0] = 1'b0;
        txn(0, 48'h0, got, lat);
        check("hold data", 64'(got), 32'hEFA72C4D);
        for (int i = 0; i < 5; i++) begin
            in_data[0]  = {16'($urandom), $urandom};
            in_valid[0] = 1'b1;
            tick();
            check($sformatf("hold out_data %0d", i), 64'(out_data[0]), 32'hEFA72C4D);
            check($sformatf("hold in_ready %0d", i), 64'(in_ready[0]), 0);
            check($sformatf("hold out_valid %0d", i), 64'(out_valid[0]), 1);
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        tick();
        check("release in_ready", 64'(in_ready[0]), 1);
        check("release out_valid", 64'(out_valid[0]), 0);

        // Sequential mode
        txn(1, 48'h6117BA866527, got, lat);
        check("seq data", 64'(got), 32'h5C82B597);
        check("seq latency", 64'(lat), 16);
        for (int i = 0; i < 16; i++)
            check($sformatf("seq sel walk %0d", i), 64'(sel_log[i]),
                  (i % 2 == 0) ? (64'd1 << (i / 2)) : 64'd0);
        tick();
        check("seq in_ready after hs", 64'(in_ready[1]), 1);

        // S3 never finishes -> timeout
        kill[0]     = 8'h04;
        in_data[0]  = {16'($urandom), $urandom};
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        err_at = -1;
        saw_ov = 0;
        for (int c = 0; c < 20; c++) begin
            if (err[0] === 1'b1 && err_at < 0) err_at = c;
            if (out_valid[0] !== 1'b0) saw_ov = 1;
            tick();
        end
        check("timeout err cycle", 64'(err_at), 6);
        check("timeout no out_valid", 64'(saw_ov), 0);
        check("timeout in_ready", 64'(in_ready[0]), 1);
        check("timeout sbox_sel", 64'(sbox_sel[0]), 0);
        kill[0] = '0;
        txn(0, 48'h0, got, lat);
        check("post-timeout data", 64'(got), 32'hEFA72C4D);
        check("post-timeout latency", 64'(lat), 9);
        check("err sticky", 64'(err[0]), 1);
        tick();

        // Reset in the 4th RUN cycle
        in_data[0]  = 48'h6117BA866527;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_reset(0, "midrun rst");
        rst = 1'b0;
        txn(0, 48'h0, got, lat);
        check("post-rst data", 64'(got), 32'hEFA72C4D);
        check("post-rst latency", 64'(lat), 9);
        tick();

        // Random words against the table model, with random output stalls
        for (int i = 0; i < 12; i++) begin
            d = i % 2;
            v = {16'($urandom), $urandom};
            h = $urandom_range(0, 3);
            out_ready[d] = 1'b0;
            txn(d, v, got, lat);
            check($sformatf("rand %0d data", i), 64'(got), 64'(ref_out(v)));
            check($sformatf("rand %0d latency", i), 64'(lat), (d == 0) ? 9 : 16);
            repeat (h) tick();
            check($sformatf("rand %0d held", i), 64'(out_data[d]), 64'(ref_out(v)));
            out_ready[d] = 1'b1;
            tick();
            check($sformatf("rand %0d in_ready", i), 64'(in_ready[d]), 1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
